// File: rtl/booth_mult_seq_pkg.sv
// Shared constants and FSM state encoding for the sequential radix-2 Booth multiplier.
package booth_mult_seq_pkg;

  localparam int N     = 32;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth step: conditional add/subtract of B on P, then an arithmetic
// right shift of the whole {P, Q, q-1} accumulator.
module booth_step #(
  parameter int N = 32
) (
  input  logic [2*N+1:0] i_acc,
  input  logic [N-1:0]   i_b,
  output logic [2*N+1:0] o_acc
);

  logic [N:0] w_p;
  logic [N:0] w_bExt;
  logic [N:0] w_bNeg;
  logic [N:0] w_addend;
  logic [N:0] w_sum;

  assign w_p    = i_acc[2*N+1:N+1];
  assign w_bExt = {i_b[N-1], i_b};
  // One extra bit keeps -(-2^(N-1)) representable.
  assign w_bNeg = ~w_bExt + {{N{1'b0}}, 1'b1};

  always_comb begin
    w_addend = '0;
    case (i_acc[1:0])
      2'b01:   w_addend = w_bExt;
      2'b10:   w_addend = w_bNeg;
      default: w_addend = '0;
    endcase
  end

  assign w_sum = w_p + w_addend;

  // Q sits in i_acc[N:1]; its LSB drops into the q-1 slot after the shift.
  assign o_acc = {w_sum[N], w_sum, i_acc[N:1]};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed N x N multiplier, one Booth recoding step per clock; busy/done
// are registered flags mirroring the CALC/DONE states.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int N = booth_mult_seq_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_r
);

  localparam int STEP_W = $clog2(N);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic                w_load;
  logic                w_step;
  logic                w_last;
  logic [STEP_W-1:0]   r_stepCnt;
  logic [N-1:0]        r_b;
  logic [2*N+1:0]      r_acc;
  logic [2*N+1:0]      w_accNext;
  logic [2*N-1:0]      r_r;
  logic                r_busy;
  logic                r_done;

  booth_step #(.N(N)) u_step (
    .i_acc (r_acc),
    .i_b   (r_b),
    .o_acc (w_accNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_nextState = CALC;
          w_load      = 1'b1;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_stepCnt == LAST_STEP) begin
          w_nextState = DONE;
          w_last      = 1'b1;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are captured at start so later input changes cannot disturb a product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b       <= '0;
      r_acc     <= '0;
      r_stepCnt <= '0;
    end else if (w_load) begin
      r_b       <= i_b;
      r_acc     <= {{(N+1){1'b0}}, i_a, 1'b0};
      r_stepCnt <= '0;
    end else if (w_step) begin
      r_acc     <= w_accNext;
      r_stepCnt <= r_stepCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_last) r_r <= w_accNext[2*N:1];
      r_busy <= (w_nextState == CALC);
      r_done <= (w_nextState == DONE);
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_r    = r_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: stimulus pushes hand-computed products,
// a negedge monitor pops them on every done pulse.
module tb_booth_mult_seq;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp;
  } expEntry_t;

  logic           clk;
  logic           rst_n;
  logic           i_en;
  logic [N-1:0]   i_a;
  logic [N-1:0]   i_b;
  logic           o_busy;
  logic           o_done;
  logic [2*N-1:0] o_r;

  expEntry_t expQ[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cycle      = 0;
  int  busyRun    = 0;
  int  lastDone   = 0;
  bit  lastDoneValid = 0;
  bit  b2b = 0;

  booth_mult_seq #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (i_en),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_r    (o_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on done, tracks busy length and pulse spacing.
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      busyRun = 0;
      lastDoneValid = 0;
    end else begin
      if (!b2b) lastDoneValid = 0;
      if (o_busy) busyRun++;
      if (o_done) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_done: got R=0x%016h, expected no done", o_r);
        end else begin
          expEntry_t e;
          e = expQ.pop_front();
          check64($sformatf("product a=%08h b=%08h", e.a, e.b), o_r, e.exp);
        end
        check64("busy_length", 64'(busyRun), 64'd32);
        if (b2b && lastDoneValid)
          check64("done_spacing", 64'(cycle - lastDone), 64'd34);
        lastDone = cycle;
        lastDoneValid = 1;
      end
      if (!o_busy) busyRun = 0;
    end
  end

  // Starts one product; the operands are scrambled right after the start edge.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [2*N-1:0] exp, input bit holdEn);
    expEntry_t e;
    e.a = a; e.b = b; e.exp = exp;
    i_a = a; i_b = b; i_en = 1'b1;
    expQ.push_back(e);
    @(posedge clk); #1;
    if (!holdEn) i_en = 1'b0;
    i_a = ~a ^ 32'h5A5A_1234;
    i_b = b + 32'd17;
  endtask

  // Waits (bounded) for done, then steps to the edge that returns the FSM to IDLE.
  task automatic checkOutput();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_timeout: got no done within 40 cycles, expected done");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; i_en = 1'b0; i_a = '0; i_b = '0;
    repeat (2) @(negedge clk);
    check64("reset_busy", 64'(o_busy), 64'd0);
    check64("reset_done", 64'(o_done), 64'd0);
    check64("reset_R",    o_r,         64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(32'd3,          32'd5,          64'h0000_0000_0000_000F, 0); checkOutput();
    applyStimulus(32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6, 0); checkOutput();
    applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 0); checkOutput();
    applyStimulus(32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 0); checkOutput();
    applyStimulus(32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000, 0); checkOutput();

    // en pulsed and operands changed mid-CALC must be ignored.
    i_a = 32'd12; i_b = 32'd12; i_en = 1'b1;
    begin
      expEntry_t e;
      e.a = 32'd12; e.b = 32'd12; e.exp = 64'h90;
      expQ.push_back(e);
    end
    @(posedge clk); #1;
    i_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i_en = 1'b1; i_a = 32'd5; i_b = 32'd7;
    @(posedge clk); #1;
    i_en = 1'b0;
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check64("idle_busy_after_ignored_en", 64'(o_busy), 64'd0);
      check64("R_hold", o_r, 64'h90);
    end
    @(posedge clk); #1;

    // Abort by reset partway through CALC.
    i_a = 32'd9; i_b = 32'd9; i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check64("abort_busy", 64'(o_busy), 64'd0);
    check64("abort_done", 64'(o_done), 64'd0);
    check64("abort_R",    o_r,         64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(32'd2, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 0); checkOutput();

    // Back-to-back with en held high.
    b2b = 1;
    applyStimulus(32'd0,         32'h8000_0000, 64'h0000_0000_0000_0000, 1); checkOutput();
    applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1); checkOutput();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1); checkOutput();
    applyStimulus(32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, 1); checkOutput();
    applyStimulus(32'd1000,      32'hFFFF_FC18, 64'hFFFF_FFFF_FFF0_BDC0, 1); checkOutput();
    applyStimulus(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1); checkOutput();
    applyStimulus(32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1); checkOutput();
    i_en = 1'b0;
    b2b = 0;

    repeat (4) @(posedge clk);
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 Parameter: N, 32, operand width in bits; product width is 2N.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst  input  1  Asynchronous, active-low reset.
REQ-004 en  input  1  Start request, sampled only in IDLE.
REQ-005 A  input  N  Multiplier, two's complement signed.
REQ-006 B  input  N  Multiplicand, two's complement signed.
REQ-007 busy  output  1  High while a multiplication is in progress.
REQ-008 done  output  1  One-cycle pulse; R holds a new valid product.
REQ-009 R  output  2N  Signed product A*B; holds its value until the next done.

Function
REQ-010 The block SHALL compute the exact signed 2N-bit product using radix-2 Booth recoding, one recoding step per clock.
REQ-011 The FSM SHALL have the states IDLE, CALC and DONE.
- IDLE->CALC when en=1.
- CALC->DONE after N steps.
- DONE->IDLE unconditionally.
REQ-012 On the IDLE edge with en=1, the block SHALL:
- latch B into an internal register;
- load the accumulator {P, Q, q-1} with P=0 (N+1 bits, sign-extended), Q=A and q-1=0;
- clear the step counter.
REQ-013 Each CALC step SHALL inspect {Q[0], q-1}:
- 01: P = P + sext(B);
- 10: P = P - sext(B), with the subtraction done as the two's complement of B;
- 00 or 11: P unchanged.
The whole (2N+2)-bit accumulator SHALL then be shifted right arithmetically by 1 in the same cycle.
REQ-014 P SHALL be N+1 bits so that B = -2^(N-1) (-B overflow) and A = -2^(N-1) give exact results without wrap.
REQ-015 On the last CALC edge (step counter = N-1), R SHALL be loaded with the low 2N bits of {P, Q} after the final shift, and the state SHALL go to DONE.
REQ-016 Latency: with en sampled at edge E0, busy SHALL be 1 after E0 through E32 exclusive. After E32 (for N=32), R SHALL be valid, done SHALL be 1 and busy SHALL be 0. After E33, done SHALL be 0 and the state SHALL be IDLE.
REQ-017 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE; both SHALL be registered, not combinational.
REQ-018 en asserted in CALC or DONE SHALL be ignored, with no restart or queuing; a new start is accepted only from IDLE.
REQ-019 Changes to A or B after the start edge SHALL NOT affect the result in flight.
REQ-020 Back-to-back operation SHALL be possible: en held high yields a new start on every IDLE visit, giving a throughput of one product per N+2 cycles.
REQ-021 R SHALL NOT change except on the final CALC edge or on reset.

Reset
REQ-022 When rst=0 (asynchronous), the block SHALL force:
- state = IDLE;
- busy = 0, done = 0, R = 0;
- accumulator, latched B and step counter = 0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no done pulse; R SHALL read 0 afterwards.
REQ-024 After rst is released, the first start SHALL be accepted on the first rising edge with en=1.

Structure
REQ-025 A shared package SHALL hold the width constant N, the FSM state enumeration (IDLE, CALC, DONE) and the step-counter width clog2(N).
REQ-026 The combinational per-step datapath SHALL be one sub-module, booth_step. It contains:
- the two's-complement negator (N to N+1 bits);
- the (N+1)-bit adder on P;
- the (2N+2)-bit arithmetic right shifter.
It takes the accumulator and B as inputs and outputs the next accumulator.
REQ-027 The top level SHALL contain only the FSM, the counter, the operand/accumulator registers and the output registers.

Verification
REQ-028 A=3, B=5, en pulse -> busy high for 32 cycles, then done=1 with R=0x0000_0000_0000_000F.
REQ-029 A=-7 (0xFFFF_FFF9), B=6 -> R=0xFFFF_FFFF_FFFF_FFD6; A=-1, B=-1 -> R=0x0000_0000_0000_0001.
REQ-030 A=0x8000_0000, B=0x8000_0000 -> R=0x4000_0000_0000_0000; A=0x7FFF_FFFF, B=0x8000_0000 -> R=0xC000_0000_8000_0000.
REQ-031 A=12, B=12 started, then en pulsed and A/B changed at cycle 10 of CALC -> result still 0x90, no extra busy period.
REQ-032 rst=0 at CALC cycle 15 -> busy=0, done=0, R=0 immediately. After release, A=2, B=-3 -> R=0xFFFF_FFFF_FFFF_FFFA.
REQ-033 Randomized signed operands (at least 1000, including 0 and ±max) with en held high -> every done carries R = A*B (64-bit signed), spaced 34 cycles apart.
